// File: rtl/fifo_tx_serializer_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter: default sizing,
// FSM state encoding and a frame-length helper.
package fifo_tx_serializer_pkg;

    localparam int DEFAULT_WIDTH        = 16;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_POP     = 3'd1;
    localparam state_t S_CAPTURE = 3'd2;
    localparam state_t S_START   = 3'd3;
    localparam state_t S_DATA    = 3'd4;
    localparam state_t S_PARITY  = 3'd5;
    localparam state_t S_STOP    = 3'd6;

    // Clock cycles on the line for one frame (start + data + optional parity + stop).
    function automatic int frame_len(input int width, input int clks_per_bit, input int parity_en);
        return (width + 2 + parity_en) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_tx_serializer_if.sv
// Pop interface between the word FIFO and its serializer.
// master: the serializer (issues get); slave: the FIFO (supplies data/flag).
interface fifo_tx_serializer_if #(
    parameter int WIDTH = fifo_tx_serializer_pkg::DEFAULT_WIDTH
) ();

    logic             fifo_empty_bar;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_get;

    modport master (
        output fifo_get,
        input  fifo_empty_bar,
        input  fifo_data
    );

    modport slave (
        input  fifo_get,
        output fifo_empty_bar,
        output fifo_data
    );

endinterface

// File: rtl/fifo_tx_serializer_baud_tick_gen.sv
// Bit-period divider: free-running counter that wraps every CLKS_PER_BIT
// cycles and flags the final cycle of each bit period. A synchronous clear
// lets the FSM align the first bit period to the start of a frame.
module fifo_tx_serializer_baud_tick_gen
    import fifo_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: wrap at the end of a bit period or when the FSM clears.
    always_comb begin
        // NOTE: assign a default first so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state updates use <= so every flop samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// FIFO-fed serial transmitter. Pops one word, then sends start bit, data
// LSB-first, optional even parity and stop bit, paced by the baud divider.
// Frames chain back-to-back while enable is high and the FIFO has data.
module fifo_tx_serializer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    fifo_tx_serializer_if.master fifo_if,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             baud_clear;
    logic             tick;

    fifo_tx_serializer_baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(baud_clear),
        .tick (tick)
    );

    // Frame sequencing, word capture/shift and the registered line value.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        parity_d   = parity_q;
        baud_clear = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_clear = 1'b1;
                if (enable && fifo_if.fifo_empty_bar) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                baud_clear = 1'b1;
                state_d    = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The FIFO presents the popped word one cycle after get.
                baud_clear = 1'b1;
                shift_d    = fifo_if.fifo_data;
                parity_d   = ^fifo_if.fifo_data;
                bit_cnt_d  = '0;
                state_d    = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_d = (enable && fifo_if.fifo_empty_bar) ? S_POP : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line value follows the state being entered, so tx is a clean flop.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State, datapath and line registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign tx               = tx_q;
    assign busy             = (state_q != S_IDLE);
    assign frame_done       = (state_q == S_STOP) && tick;
    assign fifo_if.fifo_get = (state_q == S_POP);

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench for fifo_tx_serializer. Lane 0 runs without parity, lane 1 with
// even parity. Each lane has a FIFO model, a get/done recorder and a line
// decoder that checks decoded frames against a scoreboard of expected words.
module tb_fifo_tx_serializer;
    import fifo_tx_serializer_pkg::*;

    localparam int W   = 16;
    localparam int CPB = 4;

    typedef struct packed {
        logic [W-1:0] word;
        logic         par;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] en    = 2'b00;
    logic [1:0] tx_w;
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [1:0] get_w;

    logic [W-1:0] fq [2][$];
    exp_t         exp_q [2][$];
    int           get_cyc [2][$];
    int           done_cyc [2][$];

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input logic [W-1:0] word, input logic par);
        exp_t e;
        e.word = word;
        e.par  = par;
        fq[lane].push_back(word);
        exp_q[lane].push_back(e);
    endtask

    task automatic wait_get(input int lane, input int target, input string name);
        int budget = 1000;
        while (get_cyc[lane].size() < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check(name, 32'(get_cyc[lane].size() >= target), 1);
    endtask

    task automatic wait_done(input int lane, input int target, input string name);
        int budget = 1000;
        while (done_cyc[lane].size() < target && budget > 0) begin
            tick(1);
            budget--;
        end
        check(name, 32'(done_cyc[lane].size() >= target), 1);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        fifo_tx_serializer_if #(.WIDTH(W)) fif ();

        logic [W-1:0] pend     = '0;
        logic         get_prev = 1'b0;

        fifo_tx_serializer #(
            .WIDTH(W),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN(g)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .enable    (en[g]),
            .fifo_if   (fif.master),
            .tx        (tx_w[g]),
            .busy      (busy_w[g]),
            .frame_done(done_w[g])
        );

        assign get_w[g] = fif.fifo_get;

        // Popped word appears on fifo_data from the cycle after get.
        always @(posedge clk) fif.fifo_data <= pend;

        // FIFO model plus get/frame_done recorder, sampled mid-cycle.
        initial begin
            fif.fifo_empty_bar = 1'b0;
            forever begin
                @(negedge clk);
                if (fif.fifo_get === 1'b1) begin
                    check($sformatf("lane%0d_get_while_empty", g), 32'(fq[g].size() != 0), 1);
                    check($sformatf("lane%0d_get_single_cycle", g), 32'(get_prev), 0);
                    get_cyc[g].push_back(cyc);
                    if (fq[g].size() != 0) pend = fq[g].pop_front();
                end
                get_prev = (fif.fifo_get === 1'b1);
                if (done_w[g] === 1'b1) done_cyc[g].push_back(cyc);
                fif.fifo_empty_bar = (fq[g].size() != 0);
            end
        end

        // Line decoder and scoreboard compare.
        initial begin
            logic [W-1:0] word;
            logic start_bit, stop_bit, par_bit, cur, aborted, hold_ok, done_ok;
            int   nb;
            exp_t e;
            forever begin
                @(negedge clk);
                if (reset !== 1'b0 || tx_w[g] !== 1'b0) continue;
                nb        = W + 2 + g;
                word      = '0;
                start_bit = 1'b1;
                stop_bit  = 1'b0;
                par_bit   = 1'b0;
                cur       = 1'b0;
                aborted   = 1'b0;
                hold_ok   = 1'b1;
                done_ok   = 1'b1;
                for (int b = 0; b < nb && !aborted; b++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (b != 0 || s != 0) @(negedge clk);
                        if (reset !== 1'b0) begin
                            aborted = 1'b1;
                        end else begin
                            if (s == 0) cur = tx_w[g];
                            else if (tx_w[g] !== cur) hold_ok = 1'b0;
                            if (done_w[g] !== ((b == nb - 1) && (s == CPB - 1))) done_ok = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        if (b == 0) start_bit = cur;
                        else if (b <= W) word[b-1] = cur;
                        else if (b == nb - 1) stop_bit = cur;
                        else par_bit = cur;
                    end
                end
                if (aborted) begin
                    if (exp_q[g].size() != 0) void'(exp_q[g].pop_front());
                end else if (exp_q[g].size() == 0) begin
                    check($sformatf("lane%0d_unexpected_frame", g), 32'(exp_q[g].size()), 1);
                end else begin
                    e = exp_q[g].pop_front();
                    check($sformatf("lane%0d_frame_word", g), 32'(word), 32'(e.word));
                    check($sformatf("lane%0d_start_bit", g), 32'(start_bit), 0);
                    check($sformatf("lane%0d_stop_bit", g), 32'(stop_bit), 1);
                    check($sformatf("lane%0d_bit_hold", g), 32'(hold_ok), 1);
                    check($sformatf("lane%0d_frame_done_pulse", g), 32'(done_ok), 1);
                    if (g == 1) check($sformatf("lane%0d_parity_bit", g), 32'(par_bit), 32'(e.par));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic tx_low, busy_seen, busy_ok;
        int   budget;

        tick(3);
        check("rst_tx0", 32'(tx_w[0]), 1);
        check("rst_tx1", 32'(tx_w[1]), 1);
        check("rst_busy0", 32'(busy_w[0]), 0);
        check("rst_get0", 32'(get_w[0]), 0);
        check("rst_done0", 32'(done_w[0]), 0);

        // Empty FIFO, enabled: line must stay idle.
        reset = 1'b0;
        en    = 2'b11;
        tx_low    = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx_w !== 2'b11) tx_low = 1'b1;
            if (busy_w !== 2'b00) busy_seen = 1'b1;
        end
        check("idle_tx_high", 32'(tx_low), 0);
        check("idle_busy_low", 32'(busy_seen), 0);
        check("idle_no_get", 32'(get_cyc[0].size() + get_cyc[1].size()), 0);

        // Single word, no parity.
        push(0, 16'hA5C3, 1'b0);
        wait_done(0, 1, "t2_done_timeout");
        check("t2_get_count", 32'(get_cyc[0].size()), 1);
        check("t2_done_after_capture", 32'(done_cyc[0][0] - (get_cyc[0][0] + 1)), 72);
        tick(3);
        check("t2_busy_after", 32'(busy_w[0]), 0);

        // Three preloaded words sent back-to-back.
        en[0] = 1'b0;
        push(0, 16'h0001, 1'b0);
        push(0, 16'hFFFF, 1'b0);
        push(0, 16'h8000, 1'b0);
        tick(10);
        check("t3_no_get_disabled", 32'(get_cyc[0].size()), 1);
        en[0]   = 1'b1;
        busy_ok = 1'b1;
        budget  = 1000;
        while (done_cyc[0].size() < 4 && budget > 0) begin
            tick(1);
            budget--;
            if (get_cyc[0].size() >= 2 && done_cyc[0].size() < 4 && busy_w[0] !== 1'b1) busy_ok = 1'b0;
        end
        check("t3_done_timeout", 32'(done_cyc[0].size() >= 4), 1);
        check("t3_busy_held", 32'(busy_ok), 1);
        check("t3_get_gap_1", 32'(get_cyc[0][2] - get_cyc[0][1]), 74);
        check("t3_get_gap_2", 32'(get_cyc[0][3] - get_cyc[0][2]), 74);

        // Parity lane: 0x0007 -> parity 1, 0x0003 -> parity 0.
        push(1, 16'h0007, 1'b1);
        push(1, 16'h0003, 1'b0);
        wait_done(1, 2, "t4_done_timeout");
        check("t4_get_count", 32'(get_cyc[1].size()), 2);
        check("t4_get_gap", 32'(get_cyc[1][1] - get_cyc[1][0]), 32'(frame_len(W, CPB, 1) + 2));

        // Enable dropped mid-DATA with two words queued.
        push(0, 16'h1234, 1'b0);
        push(0, 16'h5678, 1'b0);
        wait_get(0, 5, "t5_get_timeout");
        tick(20);
        en[0] = 1'b0;
        wait_done(0, 5, "t5_done1_timeout");
        tick(30);
        check("t5_no_get_disabled", 32'(get_cyc[0].size()), 5);
        check("t5_idle_busy", 32'(busy_w[0]), 0);
        en[0] = 1'b1;
        wait_done(0, 6, "t5_done2_timeout");
        check("t5_get_count", 32'(get_cyc[0].size()), 6);

        // Reset mid-DATA aborts the frame; the next word follows.
        push(0, 16'h1111, 1'b0);
        push(0, 16'h2222, 1'b0);
        wait_get(0, 7, "t6_get_timeout");
        tick(30);
        reset = 1'b1;
        tick(1);
        check("t6_reset_tx", 32'(tx_w[0]), 1);
        check("t6_reset_busy", 32'(busy_w[0]), 0);
        check("t6_reset_get", 32'(get_w[0]), 0);
        reset = 1'b0;
        wait_done(0, 7, "t6_done_timeout");
        check("t6_get_count", 32'(get_cyc[0].size()), 8);
        tick(5);
        check("sb_drain_lane0", 32'(exp_q[0].size()), 0);
        check("sb_drain_lane1", 32'(exp_q[1].size()), 0);
        check("fifo_drain_lane0", 32'(fq[0].size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_tx_serializer.md
Name: fifo_tx_serializer

Overview:
- Downstream consumer of the 16-bit word FIFO.
- Pops one word at a time using the FIFO's put/get interface and shifts it out on a single asynchronous-style serial line: start bit, data bits LSB-first, optional even parity bit, stop bit.
- Runs on the same clk as the FIFO and paces bits with an internal divider.
- Frames are sent back-to-back for as long as the FIFO is non-empty and enable is high.

Parameters:
- WIDTH, 16, data word width; must match FIFO WIDTH.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new frames to start; sampled only in IDLE and at the end of STOP.
- fifo_empty_bar  input  1  FIFO non-empty flag (high = at least one word available).
- fifo_data  input  WIDTH  FIFO read data; holds the popped word from the cycle after get is sampled.
- fifo_get  output  1  single-cycle pop request to the FIFO.
- tx  output  1  serial line; idle high.
- busy  output  1  high from POP through the last STOP cycle.
- frame_done  output  1  one-cycle pulse in the final cycle of STOP.

Behaviour:
- Reset: clk and reset are as stated above (reset synchronous, active-high; clock clk). Reset values: state=IDLE, tx=1, fifo_get=0, busy=0, frame_done=0, shift register=0, all counters=0.
- Reset mid-frame aborts the frame. tx returns high at the next edge. No get is issued and no partial word is retained.
- States: IDLE, POP, CAPTURE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - If enable && fifo_empty_bar, go to POP.
- POP:
  - fifo_get=1 for exactly this one cycle; busy=1.
  - Next state is CAPTURE unconditionally.
- CAPTURE:
  - Load shift register from fifo_data; this is the popped word, valid one cycle after get.
  - Clear bit counter and baud counter.
  - Compute parity = XOR of the word.
  - Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0].
  - Each time the baud counter reaches CLKS_PER_BIT-1: shift right, increment bit counter.
  - After WIDTH bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the last cycle.
  - In that last cycle, if enable && fifo_empty_bar, go straight to POP (no IDLE gap); otherwise go to IDLE.
- Latency: POP to first start-bit cycle is 2 clk. Frame length is (WIDTH + 2 + PARITY_EN)·CLKS_PER_BIT clk. Back-to-back frame period is that length + 2 clk.
- Counters:
  - Baud counter width = $clog2(CLKS_PER_BIT); wraps to 0 at CLKS_PER_BIT-1.
  - Bit counter width = $clog2(WIDTH+1); never wraps within a frame.
- fifo_get is never asserted when fifo_empty_bar is low. It is never asserted outside POP and never for more than one consecutive cycle.
- enable deasserted mid-frame: the current frame completes in full, then the block returns to IDLE.
- fifo_empty_bar dropping during a frame has no effect on that frame.
- FIFO underflow is impossible by construction. The FIFO must hold data stable between pops; fifo_data is sampled only in CAPTURE.
- tx is registered (glitch-free); no combinational path from inputs to tx.

Decomposition:
- Shared package: state enum type, default constants (WIDTH, CLKS_PER_BIT), and the frame-length localparam function.
- One natural sub-module, baud_tick_gen: counter producing a one-cycle tick every CLKS_PER_BIT clk, with synchronous clear from the FSM.
- Shift register, parity, and FSM stay in the top module.

Test Plan:
- Reset with FIFO empty, enable=1 → tx=1, fifo_get never asserted over 100 clk; busy=0.
- One word 16'hA5C3, PARITY_EN=0, CLKS_PER_BIT=4:
  - exactly one fifo_get pulse;
  - tx = 0, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (LSB-first), then 1, each bit held 4 clk;
  - frame_done pulses once, 72 clk after CAPTURE.
- Three words 16'h0001, 16'hFFFF, 16'h8000 preloaded:
  - three get pulses exactly 74 clk apart;
  - busy stays high throughout;
  - decoded words match in order.
- PARITY_EN=1, word 16'h0007 → parity bit 1 inserted before stop; word 16'h0003 → parity bit 0.
- enable dropped during DATA of frame 1 with 2 words queued → frame 1 completes; no second get until enable returns high; then the second word is sent.
- reset asserted mid-DATA → next cycle tx=1, busy=0, state IDLE. After release with FIFO non-empty, a fresh frame starts with the next unpopped word; the aborted word is not resent.
